// File: rtl/dff_chain_ctrl.sv
// rtl/dff_chain_ctrl.sv - command sequencer for a serial D flip-flop chain
//
// Sequences LOAD / CLEAR / PRESET / NOP commands onto a bank of WIDTH
// falling-edge D flip-flops wired as a shift chain.
//
// Ports:
//   CLK_BAR        clock, all state changes on the falling edge
//   CLR_BAR        asynchronous active-low reset
//   CMD_VALID      command present
//   CMD            00 NOP, 01 LOAD, 10 CLEAR, 11 PRESET
//   DATA_IN        LOAD word, captured at accept
//   MSB_FIRST      shift order, captured at accept
//   ABORT          abort the command in progress
//   CMD_READY      idle and able to accept
//   BUSY           command in progress
//   DONE           one-cycle completion pulse
//   SER_D          serial data into chain cell 0
//   SHIFT_EN       chain shift enable
//   LATCH          one-cycle chain output latch strobe
//   CHAIN_CLR_BAR  chain async clear, active-low
//   CHAIN_PRE_BAR  chain async preset, active-low

module dff_chain_ctrl #(
    parameter int WIDTH   = 8,
    parameter int PULSE_W = 2
) (
    input  logic             CLK_BAR,
    input  logic             CLR_BAR,
    input  logic             CMD_VALID,
    input  logic [1:0]       CMD,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             MSB_FIRST,
    input  logic             ABORT,
    output logic             CMD_READY,
    output logic             BUSY,
    output logic             DONE,
    output logic             SER_D,
    output logic             SHIFT_EN,
    output logic             LATCH,
    output logic             CHAIN_CLR_BAR,
    output logic             CHAIN_PRE_BAR
);

    localparam int BCW = $clog2(WIDTH + 1);

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_LOAD   = 2'b01;
    localparam logic [1:0] CMD_CLEAR  = 2'b10;
    localparam logic [1:0] CMD_PRESET = 2'b11;

    localparam logic [BCW-1:0] BIT_LAST   = BCW'(WIDTH);
    localparam logic [3:0]     PULSE_LAST = 4'(PULSE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_PULSE,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic [3:0]       pulse_cnt_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             ser_d_q;
    logic             shift_en_q;
    logic             latch_q;
    logic             clr_bar_q;
    logic             pre_bar_q;

    logic             accept;
    logic [WIDTH-1:0] ordered_d;
    logic [BCW-1:0]   bit_cnt_d;
    logic [3:0]       pulse_cnt_d;

    // CMD_READY is only high in IDLE or FIN, so it doubles as the accept gate
    assign accept = CMD_VALID && ready_q;

    // The shift register always emits bit 0 first; MSB-first words are
    // bit-reversed at capture so the shift path never depends on order.
    always_comb begin
        ordered_d = DATA_IN;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                ordered_d[i] = DATA_IN[WIDTH-1-i];
            end
        end
    end

    // Saturating counter increments
    always_comb begin
        bit_cnt_d   = (bit_cnt_q == BIT_LAST) ? bit_cnt_q : bit_cnt_q + 1'b1;
        pulse_cnt_d = (pulse_cnt_q == 4'hF) ? pulse_cnt_q : pulse_cnt_q + 4'd1;
    end

    always_ff @(negedge CLK_BAR or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            state_q     <= S_IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ser_d_q     <= 1'b0;
            shift_en_q  <= 1'b0;
            latch_q     <= 1'b0;
            clr_bar_q   <= 1'b1;
            pre_bar_q   <= 1'b1;
        end else begin
            // DONE and LATCH are single-cycle strobes
            done_q  <= 1'b0;
            latch_q <= 1'b0;

            case (state_q)
                // FIN behaves like IDLE for acceptance so a held request
                // starts on the edge that closes the DONE cycle.
                S_IDLE, S_FIN: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        case (CMD)
                            CMD_LOAD: begin
                                state_q    <= S_SHIFT;
                                shift_en_q <= 1'b1;
                                ser_d_q    <= ordered_d[0];
                                sreg_q     <= ordered_d >> 1;
                                bit_cnt_q  <= BCW'(1);
                            end
                            CMD_CLEAR: begin
                                state_q     <= S_PULSE;
                                clr_bar_q   <= 1'b0;
                                pulse_cnt_q <= 4'd1;
                            end
                            CMD_PRESET: begin
                                state_q     <= S_PULSE;
                                pre_bar_q   <= 1'b0;
                                pulse_cnt_q <= 4'd1;
                            end
                            default: begin
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end

                S_SHIFT: begin
                    if (ABORT) begin
                        state_q    <= S_IDLE;
                        shift_en_q <= 1'b0;
                        ser_d_q    <= 1'b0;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_q    <= S_LATCH;
                        shift_en_q <= 1'b0;
                        ser_d_q    <= 1'b0;
                        latch_q    <= 1'b1;
                    end else begin
                        ser_d_q   <= sreg_q[0];
                        sreg_q    <= sreg_q >> 1;
                        bit_cnt_q <= bit_cnt_d;
                    end
                end

                S_LATCH: begin
                    state_q <= ABORT ? S_IDLE : S_FIN;
                    done_q  <= !ABORT;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end

                S_PULSE: begin
                    if (ABORT || pulse_cnt_q == PULSE_LAST) begin
                        state_q   <= ABORT ? S_IDLE : S_FIN;
                        done_q    <= !ABORT;
                        clr_bar_q <= 1'b1;
                        pre_bar_q <= 1'b1;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_d;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    shift_en_q <= 1'b0;
                    ser_d_q    <= 1'b0;
                    clr_bar_q  <= 1'b1;
                    pre_bar_q  <= 1'b1;
                    ready_q    <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign CMD_READY     = ready_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign SER_D         = ser_d_q;
    assign SHIFT_EN      = shift_en_q;
    assign LATCH         = latch_q;
    assign CHAIN_CLR_BAR = clr_bar_q;
    assign CHAIN_PRE_BAR = pre_bar_q;

endmodule

// File: tb/tb_dff_chain_ctrl.sv
// tb/tb_dff_chain_ctrl.sv - self-checking bench for dff_chain_ctrl

module tb_dff_chain_ctrl;

    localparam int W = 8;
    localparam int P = 2;

    localparam logic [1:0] C_NOP = 2'b00, C_LOAD = 2'b01, C_CLEAR = 2'b10, C_PRESET = 2'b11;

    // {ready, busy, done, ser_d, shift_en, latch, clr_bar, pre_bar}
    localparam logic [7:0] V_RESET = 8'b0000_0011;
    localparam logic [7:0] V_IDLE  = 8'b1000_0011;
    localparam logic [7:0] V_DONE  = 8'b1010_0011;

    logic         CLK_BAR = 1'b1;
    logic         CLR_BAR = 1'b0;
    logic         CMD_VALID, MSB_FIRST, ABORT;
    logic [1:0]   CMD;
    logic [W-1:0] DATA_IN;
    logic         CMD_READY, BUSY, DONE, SER_D, SHIFT_EN, LATCH, CHAIN_CLR_BAR, CHAIN_PRE_BAR;
    logic [7:0]   outs;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] chain_m   = '0;
    logic [W-1:0] latched_m = '0;

    dff_chain_ctrl #(.WIDTH(W), .PULSE_W(P)) dut (
        .CLK_BAR(CLK_BAR), .CLR_BAR(CLR_BAR), .CMD_VALID(CMD_VALID), .CMD(CMD),
        .DATA_IN(DATA_IN), .MSB_FIRST(MSB_FIRST), .ABORT(ABORT),
        .CMD_READY(CMD_READY), .BUSY(BUSY), .DONE(DONE), .SER_D(SER_D),
        .SHIFT_EN(SHIFT_EN), .LATCH(LATCH), .CHAIN_CLR_BAR(CHAIN_CLR_BAR),
        .CHAIN_PRE_BAR(CHAIN_PRE_BAR)
    );

    always #5 CLK_BAR = ~CLK_BAR;

    assign outs = {CMD_READY, BUSY, DONE, SER_D, SHIFT_EN, LATCH, CHAIN_CLR_BAR, CHAIN_PRE_BAR};

    // Behavioural flip-flop bank: cell 0 is bit 0, each cell feeds the next
    always @(negedge CLK_BAR or negedge CHAIN_CLR_BAR or negedge CHAIN_PRE_BAR) begin
        if (!CHAIN_CLR_BAR)      chain_m <= '0;
        else if (!CHAIN_PRE_BAR) chain_m <= '1;
        else if (SHIFT_EN)       chain_m <= {chain_m[W-2:0], SER_D};
    end

    always @(negedge CLK_BAR) begin
        if (LATCH) latched_m <= chain_m;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    function automatic int latency(input logic [1:0] c);
        case (c)
            C_LOAD:            return W + 2;
            C_CLEAR, C_PRESET: return P + 1;
            default:           return 1;
        endcase
    endfunction

    // Expected outputs during cycle cyc after the accept edge (cycle 1 is
    // the one that starts at the accept edge).
    function automatic logic [7:0] exp_vec(input logic [1:0] c, input logic [W-1:0] d,
                                           input logic m, input int cyc, input int abort_at);
        logic [W-1:0] dd;
        logic         b;
        dd = d;
        if (abort_at != 0 && cyc > abort_at) return V_IDLE;
        if (cyc == latency(c)) return V_DONE;
        case (c)
            C_LOAD: begin
                if (cyc <= W) begin
                    b = m ? dd[W-cyc] : dd[cyc-1];
                    return {3'b010, b, 4'b1011};
                end
                return 8'b0100_0111;
            end
            C_CLEAR:  return 8'b0100_0001;
            C_PRESET: return 8'b0100_0010;
            default:  return V_DONE;
        endcase
    endfunction

    // Entered just after a rising edge in a cycle where CMD_READY should be 1
    task automatic run_cmd(input logic [1:0] c, input logic [W-1:0] d, input logic m,
                           input int abort_at, input bit noise, input bit abort_idle);
        int lat;
        lat = latency(c);
        check_eq($sformatf("ready_before_cmd%0d", c), CMD_READY, 1);
        CMD_VALID = 1'b1; CMD = c; DATA_IN = d; MSB_FIRST = m; ABORT = abort_idle;
        @(posedge CLK_BAR);
        CMD_VALID = 1'b0; ABORT = 1'b0;
        DATA_IN = W'($urandom); MSB_FIRST = 1'($urandom);
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            check_eq($sformatf("cmd%0d_d%0h_m%0d_cyc%0d", c, d, m, cyc), outs,
                     exp_vec(c, d, m, cyc, abort_at));
            if (abort_at != 0 && cyc == abort_at + 1) break;
            if (abort_at == 0 && cyc == lat) break;
            ABORT = (cyc == abort_at);
            CMD_VALID = noise & 1'($urandom);
            CMD = 2'($urandom);
            @(posedge CLK_BAR);
            ABORT = 1'b0; CMD_VALID = 1'b0;
        end
        if (abort_at == 0) begin
            if (c == C_LOAD)   check_eq("latched_word", latched_m, m ? d : bitrev(d));
            if (c == C_CLEAR)  check_eq("chain_cleared", chain_m, '0);
            if (c == C_PRESET) check_eq("chain_preset", chain_m, {W{1'b1}});
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ABORT = 1'($urandom);
            @(posedge CLK_BAR);
            ABORT = 1'b0;
            check_eq("idle", outs, V_IDLE);
        end
    endtask

    initial begin
        CMD_VALID = 1'b0; CMD = C_NOP; DATA_IN = '0; MSB_FIRST = 1'b0; ABORT = 1'b0;
        @(posedge CLK_BAR);
        @(posedge CLK_BAR);
        check_eq("reset_outputs", outs, V_RESET);
        CLR_BAR = 1'b1;
        #1 check_eq("release_no_edge", outs, V_RESET);
        @(posedge CLK_BAR);
        check_eq("first_edge_ready", outs, V_IDLE);

        run_cmd(C_LOAD, 8'hA5, 1'b0, 0, 1'b0, 1'b0);
        run_cmd(C_LOAD, 8'h3C, 1'b1, 0, 1'b1, 1'b0);
        run_cmd(C_CLEAR, 8'h00, 1'b0, 0, 1'b1, 1'b0);
        run_cmd(C_PRESET, 8'h00, 1'b0, 0, 1'b1, 1'b0);
        idle_cycles(2);
        run_cmd(C_LOAD, 8'h5A, 1'b0, 4, 1'b1, 1'b0);
        run_cmd(C_NOP, 8'h00, 1'b0, 0, 1'b0, 1'b1);
        run_cmd(C_LOAD, 8'h81, 1'b1, 0, 1'b0, 1'b1);

        for (int n = 0; n < 100; n++) begin
            logic [1:0] c;
            int         ab;
            c  = 2'($urandom);
            ab = 0;
            if (c != C_NOP && $urandom_range(0, 4) == 0) ab = $urandom_range(1, latency(c) - 1);
            run_cmd(c, W'($urandom), 1'($urandom), ab, 1'b1, 1'($urandom));
            idle_cycles($urandom_range(0, 2));
        end

        // Reset dropped while the preset pulse is low
        CMD_VALID = 1'b1; CMD = C_PRESET;
        @(posedge CLK_BAR);
        CMD_VALID = 1'b0;
        check_eq("mid_preset_pre_low", CHAIN_PRE_BAR, 0);
        CLR_BAR = 1'b0;
        #1 check_eq("async_reset_outputs", outs, V_RESET);
        @(posedge CLK_BAR);
        check_eq("held_reset_outputs", outs, V_RESET);
        CLR_BAR = 1'b1;
        @(posedge CLK_BAR);
        check_eq("ready_after_rerelease", outs, V_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
